// File: rtl/apb_pkg.sv
// Shared types and constants for the APB initiator and the transceiver register map.
package apb_pkg;

   localparam int APB_DW = 32;
   localparam int APB_AW = 32;

   localparam logic [APB_AW-1:0] CTRL_ADDR = 32'h0000_0000;
   localparam logic [APB_AW-1:0] TX_ADDR   = 32'h0000_0004;
   localparam logic [APB_AW-1:0] RX_ADDR   = 32'h0000_0008;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer on the bus, one response out.
// Wait states on pready are bounded by TIMEOUT ACCESS cycles (0 = unbounded).
module apb_master
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [APB_AW-1:0] cmd_addr,
   input  logic [APB_DW-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [APB_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [APB_AW-1:0] paddr,
   output logic [APB_DW-1:0] pwdata,
   input  logic [APB_DW-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   apb_state_t       state_q;
   logic [CNT_W-1:0] wait_cnt_q;
   logic             timeout_hit;

   // Abort fires on the TIMEOUT-th ACCESS cycle, so the bus sees exactly TIMEOUT of them.
   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

   assign cmd_ready = (state_q == IDLE);
   assign psel      = (state_q == SETUP) || (state_q == ACCESS);
   assign penable   = (state_q == ACCESS);
   assign rsp_valid = (state_q == RESP);

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         paddr      <= '0;
         pwrite     <= 1'b0;
         pwdata     <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_addr[1:0] != 2'b00) begin
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     state_q   <= RESP;
                  end else begin
                     paddr   <= cmd_addr;
                     pwrite  <= cmd_write;
                     pwdata  <= cmd_wdata;
                     state_q <= SETUP;
                  end
               end
            end
            SETUP: begin
               wait_cnt_q <= '0;
               state_q    <= ACCESS;
            end
            ACCESS: begin
               if (pready) begin
                  // Read data is only returned for clean reads; writes and errors report 0.
                  rsp_rdata <= (pwrite || pslverr) ? '0 : prdata;
                  rsp_err   <= pslverr;
                  state_q   <= RESP;
               end else if (timeout_hit) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master: a bus-level slave plus a transaction-level expectation model.
module tb_apb_master;
   import apb_pkg::*;

   localparam int TIMEOUT = 16;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 pclk = ~pclk;

   apb_master #(.TIMEOUT(TIMEOUT)) dut (
      .pclk      (pclk),
      .preset    (preset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Issue one command; the slave inserts wait_n low-pready cycles, then completes with serr/rdat.
   task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wait_n, input logic serr, input logic [31:0] rdat,
                          input int hold);
      logic        mis, tmo, exp_err;
      logic [31:0] exp_rd;
      int          exp_acc, exp_lat;
      int          cyc, n_setup, n_acc, bus_bad;
      bit          done;

      mis     = (addr[1:0] != 2'b00);
      tmo     = !mis && (TIMEOUT != 0) && (wait_n >= TIMEOUT);
      exp_acc = mis ? 0 : (tmo ? TIMEOUT : wait_n + 1);
      exp_lat = mis ? 1 : 2 + exp_acc;
      exp_err = mis || tmo || serr;
      exp_rd  = (exp_err || wr) ? 32'h0 : rdat;

      @(negedge pclk);
      chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
      cmd_write = 1'($urandom);

      cyc = 0; n_setup = 0; n_acc = 0; bus_bad = 0; done = 0;
      while (!done && cyc < 64) begin
         @(negedge pclk);
         cyc++;
         if (rsp_valid) begin
            done = 1;
         end else begin
            if (psel && !penable) n_setup++;
            if (psel && penable) begin
               n_acc++;
               if (paddr !== addr || pwrite !== wr || pwdata !== wdata) bus_bad++;
               pready  = (n_acc > wait_n);
               pslverr = pready ? serr : 1'($urandom);
               prdata  = pready ? rdat : $urandom;
            end else begin
               pready  = 1'b0;
               pslverr = 1'($urandom);
               prdata  = $urandom;
            end
         end
      end
      pready  = 1'b0;
      pslverr = 1'b0;

      if (!done) chk("rsp_valid_bound", 32'd0, 32'd1);
      chk("setup_cycles", n_setup, mis ? 32'd0 : 32'd1);
      chk("access_cycles", n_acc, exp_acc);
      chk("rsp_latency", cyc, exp_lat);
      chk("bus_hold", bus_bad, 32'd0);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      chk("rsp_rdata", rsp_rdata, exp_rd);

      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
         chk("hold_psel", {31'b0, psel}, 32'd0);
         @(negedge pclk);
      end
      rsp_ready = 1'b1;
      @(posedge pclk);
      #1;
      rsp_ready = 1'b0;
      @(negedge pclk);
      chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("post_cmd_ready", {31'b0, cmd_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      logic        w;
      int          sel;

      preset    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      rsp_ready = 1'b0;
      prdata    = '0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("rst_outputs", {24'b0, rsp_valid, rsp_err, psel, penable, pwrite, 3'b0}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_paddr", paddr, 32'd0);
      chk("rst_pwdata", pwdata, 32'd0);
      preset = 1'b1;

      run_cmd(1'b1, CTRL_ADDR, 32'h0000_1A2B, 0, 1'b0, 32'h5555_AAAA, 0);
      run_cmd(1'b0, RX_ADDR, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1);
      run_cmd(1'b1, TX_ADDR, 32'hCAFE_0001, 0, 1'b1, 32'h0, 3);
      run_cmd(1'b0, RX_ADDR, 32'h0, 1000, 1'b0, 32'h1111_2222, 0);
      run_cmd(1'b0, RX_ADDR, 32'h0, TIMEOUT - 1, 1'b0, 32'h3333_4444, 0);
      run_cmd(1'b1, 32'h0000_0006, 32'h7777_7777, 0, 1'b0, 32'h0, 1);
      run_cmd(1'b0, RX_ADDR, 32'h0, 0, 1'b0, 32'h1234_5678, 5);

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 5);
         case (sel)
            0:       a = CTRL_ADDR;
            1:       a = TX_ADDR;
            2:       a = RX_ADDR;
            3:       a = {$urandom} | 32'h1;
            default: a = {$urandom} & 32'hFFFF_FFFC;
         endcase
         w = 1'($urandom);
         run_cmd(w, a, $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 4),
                 1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
      end

      // Reset asserted in the second ACCESS cycle of a stalled read.
      @(negedge pclk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = RX_ADDR;
      cmd_wdata = 32'h9999_0000;
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge pclk);
      chk("pre_rst_access", {30'b0, psel, penable}, 32'd3);
      preset = 1'b0;
      #1;
      chk("midrst_bus", {29'b0, psel, penable, pwrite}, 32'd0);
      chk("midrst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
      chk("midrst_paddr", paddr, 32'd0);
      chk("midrst_pwdata", pwdata, 32'd0);
      chk("midrst_rdata", rsp_rdata, 32'd0);
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      chk("postrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      chk("postrst_psel", {31'b0, psel}, 32'd0);

      run_cmd(1'b0, RX_ADDR, 32'h0, 2, 1'b0, 32'hABCD_0123, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion (%0d/%0d so far)", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
